// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: run controller for the MIPS SOPC.
//   Holds the CPU in reset for RST_CYCLES cycles. It then lets the CPU run and
//   counts run cycles. The run ends on one of three events: a signature write,
//   a stalled PC or a cycle timeout. The CPU is frozen (cpu_rst_o=1) in FINISH
//   until restart_i is seen.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   restart_i                start a new run (only acted on in FINISH)
//   pc_i                     CPU fetch PC (used to detect a halt)
//   mem_we_i/addr_i/data_i   CPU data-memory write bus (signature snoop)
//   cpu_rst_o                reset to the CPU
//   running_o, done_o        phase status
//   pass_o/fail_o/stall_o/timeout_o  end-of-run cause (at most one is set)
//   result_o                 captured signature value
//   cycle_cnt_o              RUN cycles elapsed
module sopc_run_ctrl #(
    parameter int              RST_CYCLES  = 3,
    parameter int              MAX_CYCLES  = 40,
    parameter int              CNT_W       = 16,
    parameter int              PC_W        = 32,
    parameter int              DATA_W      = 32,
    parameter int              STALL_LIMIT = 8,
    parameter logic [PC_W-1:0] SIG_ADDR    = 'h100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              mem_we_i,
    input  logic [PC_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              cpu_rst_o,
    output logic              running_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              stall_o,
    output logic              timeout_o,
    output logic [DATA_W-1:0] result_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW = $clog2(STALL_LIMIT);
    localparam logic [HW-1:0]    HOLD_LAST  = HW'(RST_CYCLES - 1);
    localparam logic [SW-1:0]    STALL_LAST = SW'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_FINISH} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic [SW-1:0]   stall_cnt;
    logic [PC_W-1:0] last_pc;
    logic            pc_same, sig_hit, stall_hit, tmo_hit;

    // End-of-run events, all evaluated on the current cycle's inputs.
    // stall_cnt never passes STALL_LAST in RUN: reaching it with an unchanged
    // PC always ends the run.
    always_comb begin
        pc_same   = (pc_i == last_pc);
        sig_hit   = mem_we_i && (mem_addr_i == SIG_ADDR);
        stall_hit = pc_same && (stall_cnt == STALL_LAST);
        tmo_hit   = (cycle_cnt_o == CNT_LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HOLD:   if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            S_RUN:    if (sig_hit || stall_hit || tmo_hit) state_nxt = S_FINISH;
            S_FINISH: if (restart_i) state_nxt = S_HOLD;
            default:  state_nxt = S_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_HOLD;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst_o   <= 1'b1;
            running_o   <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            stall_o     <= 1'b0;
            timeout_o   <= 1'b0;
            result_o    <= '0;
            cycle_cnt_o <= '0;
            hold_cnt    <= '0;
            stall_cnt   <= '0;
            last_pc     <= '0;
        end else begin
            // Phase outputs are flopped from the next state so they line up
            // with the state register without decode glitches.
            cpu_rst_o <= (state_nxt != S_RUN);
            running_o <= (state_nxt == S_RUN);
            done_o    <= (state_nxt == S_FINISH);
            case (state)
                S_HOLD: begin
                    hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
                end
                S_RUN: begin
                    // Counts on the ending cycle too, so the final value is
                    // the number of RUN cycles.
                    cycle_cnt_o <= cycle_cnt_o + 1'b1;
                    last_pc     <= pc_i;
                    stall_cnt   <= pc_same ? stall_cnt + 1'b1 : '0;
                    if (sig_hit) begin
                        result_o <= mem_data_i;
                        pass_o   <= (mem_data_i == '0);
                        fail_o   <= (mem_data_i != '0);
                    end else if (stall_hit) begin
                        stall_o <= 1'b1;
                    end else if (tmo_hit) begin
                        timeout_o <= 1'b1;
                    end
                end
                S_FINISH: begin
                    if (restart_i) begin
                        pass_o      <= 1'b0;
                        fail_o      <= 1'b0;
                        stall_o     <= 1'b0;
                        timeout_o   <= 1'b0;
                        result_o    <= '0;
                        cycle_cnt_o <= '0;
                        stall_cnt   <= '0;
                        last_pc     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Bench for sopc_run_ctrl: hand-written reset/restart/mid-run-reset
// sequences plus a table of run scenarios whose expected end state is
// queued when the scenario starts and compared when done_o rises.
module tb_sopc_run_ctrl;

    localparam int          RST_CYCLES = 3;
    localparam logic [31:0] SIG        = 32'h100;

    logic        clk, rst, restart_i, mem_we_i;
    logic [31:0] pc_i, mem_addr_i, mem_data_i;
    logic        cpu_rst_o, running_o, done_o, pass_o, fail_o, stall_o, timeout_o;
    logic [31:0] result_o;
    logic [15:0] cycle_cnt_o;

    sopc_run_ctrl dut (
        .clk(clk), .rst(rst), .restart_i(restart_i), .pc_i(pc_i),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .cpu_rst_o(cpu_rst_o), .running_o(running_o), .done_o(done_o),
        .pass_o(pass_o), .fail_o(fail_o), .stall_o(stall_o), .timeout_o(timeout_o),
        .result_o(result_o), .cycle_cnt_o(cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          pass, fail, stall, tmo;
        logic [31:0] result;
        int          cnt;
    } res_t;

    typedef struct {
        string       name;
        int          sig_k;     // RUN cycle of the signature write, -1 = none
        logic [31:0] sig_data;
        int          stall_k;   // RUN cycle from which PC is frozen, -1 = never
        logic [31:0] stall_pc;
        bit          decoy;     // near-miss writes and a restart pulse in RUN
        res_t        exp;
    } scn_t;

    res_t sb_q[$];
    scn_t scn[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic scn_t mk(input string n, input int sk, input logic [31:0] sd,
                                input int tk, input logic [31:0] tp, input bit dc,
                                input bit p, input bit f, input bit s, input bit t,
                                input logic [31:0] r, input int c);
        scn_t x;
        x.name = n; x.sig_k = sk; x.sig_data = sd; x.stall_k = tk; x.stall_pc = tp;
        x.decoy = dc;
        x.exp.pass = p; x.exp.fail = f; x.exp.stall = s; x.exp.tmo = t;
        x.exp.result = r; x.exp.cnt = c;
        return x;
    endfunction

    task automatic idle_inputs();
        restart_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    endtask

    // Called with the DUT in HOLD (hold_cnt=0) as seen just after an edge.
    // A signature write is held on the bus throughout HOLD and must be ignored.
    task automatic hold_to_run(input string tag);
        mem_we_i = 1'b1; mem_addr_i = SIG; mem_data_i = '0; pc_i = '0;
        for (int i = 0; i < RST_CYCLES - 1; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_cpu_rst"}, cpu_rst_o, 1);
            chk({tag, "_hold_running"}, running_o, 0);
        end
        @(posedge clk); #1;
        chk({tag, "_run_running"}, running_o, 1);
        chk({tag, "_run_cpu_rst"}, cpu_rst_o, 0);
        chk({tag, "_run_cnt0"}, cycle_cnt_o, 0);
        chk({tag, "_run_no_done"}, done_o, 0);
        chk({tag, "_run_no_pass"}, pass_o, 0);
        idle_inputs();
    endtask

    task automatic do_restart(input string tag);
        restart_i = 1'b1;
        @(posedge clk); #1;
        restart_i = 1'b0;
        chk({tag, "_rs_cpu_rst"}, cpu_rst_o, 1);
        chk({tag, "_rs_done"}, done_o, 0);
        chk({tag, "_rs_flags"}, {pass_o, fail_o, stall_o, timeout_o}, 0);
        chk({tag, "_rs_cnt"}, cycle_cnt_o, 0);
        chk({tag, "_rs_result"}, result_o, 0);
        hold_to_run(tag);
    endtask

    // Called at the first RUN cycle (cycle_cnt_o=0 visible).
    task automatic run_scn(input scn_t s);
        res_t e;
        int   k = 0;
        sb_q.push_back(s.exp);
        while (!done_o && k < 60) begin
            idle_inputs();
            pc_i = (s.stall_k >= 0 && k >= s.stall_k) ? s.stall_pc : 32'h1000 + 32'(4 * k);
            if (k == s.sig_k) begin
                mem_we_i = 1'b1; mem_addr_i = SIG; mem_data_i = s.sig_data;
            end
            if (s.decoy) begin
                if (k == 2) restart_i = 1'b1;
                if (k == 5) begin mem_we_i = 1'b1; mem_addr_i = SIG + 4; end
                if (k == 6) begin mem_we_i = 1'b0; mem_addr_i = SIG; end
            end
            @(posedge clk); #1;
            k++;
            if (!done_o) begin
                chk({s.name, "_cnt_track"}, cycle_cnt_o, 64'(k));
                chk({s.name, "_cpu_rst_low"}, cpu_rst_o, 0);
            end
        end
        idle_inputs();
        if (!done_o) begin
            checks++; errors++;
            $display("FAIL %s_end: done_o never rose within 60 cycles", s.name);
        end
        e = sb_q.pop_front();
        chk({s.name, "_running"}, running_o, 0);
        chk({s.name, "_cpu_rst"}, cpu_rst_o, 1);
        chk({s.name, "_pass"}, pass_o, 64'(e.pass));
        chk({s.name, "_fail"}, fail_o, 64'(e.fail));
        chk({s.name, "_stall"}, stall_o, 64'(e.stall));
        chk({s.name, "_timeout"}, timeout_o, 64'(e.tmo));
        chk({s.name, "_result"}, result_o, 64'(e.result));
        chk({s.name, "_cnt"}, cycle_cnt_o, 64'(e.cnt));
        // FINISH must hold everything even with a signature write on the bus.
        mem_we_i = 1'b1; mem_addr_i = SIG; mem_data_i = 32'h99; pc_i = $urandom;
        @(posedge clk); #1;
        idle_inputs();
        chk({s.name, "_hold_done"}, done_o, 1);
        chk({s.name, "_hold_result"}, result_o, 64'(e.result));
        chk({s.name, "_hold_cnt"}, cycle_cnt_o, 64'(e.cnt));
        chk({s.name, "_hold_flags"}, {pass_o, fail_o, stall_o, timeout_o},
            {60'd0, e.pass, e.fail, e.stall, e.tmo});
    endtask

    // Starts from the first RUN cycle; rst lands on RUN cycle 5.
    task automatic midrun_reset();
        for (int k = 0; k < 5; k++) begin
            pc_i = 32'h2000 + 32'(4 * k);
            @(posedge clk); #1;
        end
        chk("mid_cnt5", cycle_cnt_o, 5);
        rst = 1'b1; mem_we_i = 1'b1; mem_addr_i = SIG; mem_data_i = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_cpu_rst", cpu_rst_o, 1);
        chk("mid_cnt", cycle_cnt_o, 0);
        chk("mid_running", running_o, 0);
        chk("mid_done", done_o, 0);
        chk("mid_pass", pass_o, 0);
        hold_to_run("mid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        scn[0] = mk("pass",       10, 32'h0, -1, 32'h0,  0, 1, 0, 0, 0, 32'h0, 11);
        scn[1] = mk("fail_prio",  11, 32'h5,  3, 32'h20, 0, 0, 1, 0, 0, 32'h5, 12);
        scn[2] = mk("stall",      -1, 32'h0,  3, 32'h20, 0, 0, 0, 1, 0, 32'h0, 12);
        scn[3] = mk("timeout",    -1, 32'h0, -1, 32'h0,  1, 0, 0, 0, 1, 32'h0, 40);
        scn[4] = mk("pc0_stall",  -1, 32'h0,  0, 32'h0,  0, 0, 0, 1, 0, 32'h0, 8);
        scn[5] = mk("sig_first",   0, 32'h7, -1, 32'h0,  0, 0, 1, 0, 0, 32'h7, 1);
        scn[6] = mk("sig_vs_tmo", 39, 32'h0, -1, 32'h0,  0, 1, 0, 0, 0, 32'h0, 40);

        rst = 1'b1; pc_i = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", cpu_rst_o, 1);
        chk("rst_running", running_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_flags", {pass_o, fail_o, stall_o, timeout_o}, 0);
        chk("rst_cnt", cycle_cnt_o, 0);
        chk("rst_result", result_o, 0);
        rst = 1'b0;
        hold_to_run("rst");

        for (int i = 0; i < 7; i++) begin
            if (i > 0) do_restart(scn[i].name);
            if (i == 3) midrun_reset();
            run_scn(scn[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
